// File: rtl/player_move_ctrl_pkg.sv
// Shared game definitions: direction encodings, movement FSM states and
// default screen bounds used by the player movement controller.
package player_move_ctrl_pkg;

    // One-hot direction codes, bit order {up, down, left, right}
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    // Visible playfield bounds for the sprite's top-left corner
    localparam int SCR_X_MIN = 0;
    localparam int SCR_X_MAX = 608;
    localparam int SCR_Y_MIN = 0;
    localparam int SCR_Y_MAX = 448;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } moveState_t;

endpackage

// File: rtl/player_move_ctrl_tick_gen.sv
// Free-running clock divider producing a registered single-cycle game tick
// once every TICK_DIV clocks.
module player_move_ctrl_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1 and flag the wrap one cycle later as the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_LAST);
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement controller: synchronizes the direction buttons, picks one
// direction per game tick and steps the sprite position within the screen
// bounds, then ignores the collision enables while they settle.
module player_move_ctrl
    import player_move_ctrl_pkg::*;
#(
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int X_MIN      = SCR_X_MIN,
    parameter int X_MAX      = SCR_X_MAX,
    parameter int Y_MIN      = SCR_Y_MIN,
    parameter int Y_MAX      = SCR_Y_MAX,
    parameter int X_INIT     = 100,
    parameter int Y_INIT     = 100,
    parameter int STEP       = 1,
    parameter int TICK_DIV   = 833333,
    parameter int SETTLE_CYC = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           btn_up,
    input  logic           btn_down,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           up_en,
    input  logic           down_en,
    input  logic           left_en,
    input  logic           right_en,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [3:0]     dir,
    output logic           moved,
    output logic           blocked,
    output logic           settling
);

    localparam int SW = $clog2(SETTLE_CYC + 1);

    // Clamp a stepped coordinate into [lo, hi]; equal to cur means "at bound"
    function automatic int satStep(input int cur, input int delta, input int lo, input int hi);
        int n;
        n = cur + delta;
        if (n < lo)
            n = lo;
        else if (n > hi)
            n = hi;
        return n;
    endfunction

    logic [3:0]    btnRaw;
    logic [3:0]    btnSync_p0;
    logic [3:0]    btnSync_p1;
    logic          tick;
    moveState_t    state, stateNext;
    logic [SW-1:0] settleCnt, settleNext;
    logic [X_W-1:0] posXNext, candX;
    logic [Y_W-1:0] posYNext, candY;
    logic [3:0]    dirNext, selDir;
    logic          selEn;
    logic          movedNext, blockedNext;
    int            upY, downY, leftX, rightX;

    assign btnRaw = {btn_up, btn_down, btn_left, btn_right};

    // Saturated candidate coordinate for each direction
    assign upY    = satStep(int'(pos_y), -STEP, Y_MIN, Y_MAX);
    assign downY  = satStep(int'(pos_y),  STEP, Y_MIN, Y_MAX);
    assign leftX  = satStep(int'(pos_x), -STEP, X_MIN, X_MAX);
    assign rightX = satStep(int'(pos_x),  STEP, X_MIN, X_MAX);

    player_move_ctrl_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tickGen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous button levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btnSync_p0 <= '0;
            btnSync_p1 <= '0;
        end else begin
            btnSync_p0 <= btnRaw;
            btnSync_p1 <= btnSync_p0;
        end
    end

    // Direction select, bound check and state transitions for one tick
    always_comb begin
        stateNext   = state;
        settleNext  = settleCnt;
        posXNext    = pos_x;
        posYNext    = pos_y;
        dirNext     = dir;
        movedNext   = 1'b0;
        blockedNext = 1'b0;
        selDir      = DIR_NONE;
        selEn       = 1'b0;
        candX       = pos_x;
        candY       = pos_y;
        case (state)
            ST_IDLE: begin
                if (tick && (btnSync_p1 != 4'b0000)) begin
                    // Fixed priority; lower directions never act as fallback
                    if (btnSync_p1[3]) begin
                        selDir = DIR_UP;
                        selEn  = up_en;
                        candY  = Y_W'(upY);
                    end else if (btnSync_p1[2]) begin
                        selDir = DIR_DOWN;
                        selEn  = down_en;
                        candY  = Y_W'(downY);
                    end else if (btnSync_p1[1]) begin
                        selDir = DIR_LEFT;
                        selEn  = left_en;
                        candX  = X_W'(leftX);
                    end else begin
                        selDir = DIR_RIGHT;
                        selEn  = right_en;
                        candX  = X_W'(rightX);
                    end
                    dirNext = selDir;
                    if (selEn && ((candX != pos_x) || (candY != pos_y))) begin
                        posXNext   = candX;
                        posYNext   = candY;
                        movedNext  = 1'b1;
                        stateNext  = ST_SETTLE;
                        settleNext = SW'(SETTLE_CYC - 1);
                    end else begin
                        blockedNext = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                // Collision results for the new position are not valid yet
                if (settleCnt == '0)
                    stateNext = ST_IDLE;
                else
                    settleNext = settleCnt - 1'b1;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Position, direction, pulse and FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            settleCnt <= '0;
            pos_x     <= X_W'(X_INIT);
            pos_y     <= Y_W'(Y_INIT);
            dir       <= DIR_NONE;
            moved     <= 1'b0;
            blocked   <= 1'b0;
        end else begin
            state     <= stateNext;
            settleCnt <= settleNext;
            pos_x     <= posXNext;
            pos_y     <= posYNext;
            dir       <= dirNext;
            moved     <= movedNext;
            blocked   <= blockedNext;
        end
    end

    assign settling = (state == ST_SETTLE);

endmodule

// File: tb/tb_player_move_ctrl.sv
// Scoreboard bench for player_move_ctrl: stimulus queues the expected
// moved/blocked responses, a monitor pops and compares on every pulse.
module tb_player_move_ctrl;

    typedef struct {
        logic       mv;
        logic       bl;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       up_en, down_en, left_en, right_en;
    logic [9:0] pos_x, pos_y;
    logic [3:0] dir;
    logic       moved, blocked, settling;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    player_move_ctrl #(
        .X_W       (10),
        .Y_W       (10),
        .X_MIN     (0),
        .X_MAX     (102),
        .Y_MIN     (0),
        .Y_MAX     (448),
        .X_INIT    (100),
        .Y_INIT    (100),
        .STEP      (1),
        .TICK_DIV  (4),
        .SETTLE_CYC(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .up_en    (up_en),
        .down_en  (down_en),
        .left_en  (left_en),
        .right_en (right_en),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .dir      (dir),
        .moved    (moved),
        .blocked  (blocked),
        .settling (settling)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic setBtn(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic setEn(input logic [3:0] e);
        {up_en, down_en, left_en, right_en} = e;
    endtask

    task automatic pushExp(input logic mv, input logic bl, input int x, input int y, input logic [3:0] d);
        exp_t e;
        e.mv = mv;
        e.bl = bl;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.d  = d;
        expQ.push_back(e);
    endtask

    task automatic waitEmpty(input string name);
        for (int i = 0; i < 80 && expQ.size() != 0; i++)
            @(posedge clk);
        #1;
        chk({name, "_pending"}, expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic drain(input string name);
        waitEmpty(name);
        setBtn(4'b0000);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        setBtn(4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every moved/blocked pulse must match the head of the queue
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (moved || blocked)) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpectedPulse: got moved=%0b blocked=%0b pos=(%0d,%0d), required no pulse",
                             moved, blocked, pos_x, pos_y);
                end else begin
                    e = expQ.pop_front();
                    chk("moved", moved, e.mv);
                    chk("blocked", blocked, e.bl);
                    chk("pos_x", pos_x, e.x);
                    chk("pos_y", pos_y, e.y);
                    chk("dir", dir, e.d);
                    if (e.mv) begin
                        chk("settleCyc1", settling, 1);
                        @(negedge clk);
                        if (rst_n) chk("settleCyc2", settling, 1);
                        @(negedge clk);
                        if (rst_n) chk("settleEnd", settling, 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        rst_n = 1'b0;
        setBtn(4'b0000);
        setEn(4'b0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pos_x", pos_x, 100);
        chk("rst_pos_y", pos_y, 100);
        chk("rst_dir", dir, 0);
        chk("rst_moved", moved, 0);
        chk("rst_blocked", blocked, 0);
        chk("rst_settling", settling, 0);
        rst_n = 1'b1;

        // No buttons for 40 cycles: no pulses, position held
        repeat (40) @(posedge clk);
        #1;
        chk("idle_pos_x", pos_x, 100);
        chk("idle_pos_y", pos_y, 100);

        // Walk right into X_MAX=102, then blocked at the bound
        setEn(4'b0001);
        setBtn(4'b0001);
        pushExp(1, 0, 101, 100, 4'b0001);
        pushExp(1, 0, 102, 100, 4'b0001);
        pushExp(0, 1, 102, 100, 4'b0001);
        pushExp(0, 1, 102, 100, 4'b0001);
        drain("walkRight");

        // Right requested but collision disables it
        pulseReset();
        setEn(4'b1110);
        setBtn(4'b0001);
        pushExp(0, 1, 100, 100, 4'b0001);
        pushExp(0, 1, 100, 100, 4'b0001);
        drain("rightDisabled");

        // Up wins priority and is blocked; left must not be taken instead
        setEn(4'b0111);
        setBtn(4'b1010);
        pushExp(0, 1, 100, 100, 4'b1000);
        pushExp(0, 1, 100, 100, 4'b1000);
        drain("noFallThrough");

        // Single steps in the remaining directions
        setEn(4'b1111);
        setBtn(4'b0010);
        pushExp(1, 0, 99, 100, 4'b0010);
        drain("stepLeft");
        setBtn(4'b0100);
        pushExp(1, 0, 99, 101, 4'b0100);
        drain("stepDown");
        setBtn(4'b1000);
        pushExp(1, 0, 99, 100, 4'b1000);
        drain("stepUp");

        // Reset while settling after a move to (101,100)
        pulseReset();
        setEn(4'b1111);
        setBtn(4'b0001);
        pushExp(1, 0, 101, 100, 4'b0001);
        waitEmpty("preResetMove");
        chk("midSettle_settling", settling, 1);
        rst_n = 1'b0;
        #1;
        chk("rstMid_pos_x", pos_x, 100);
        chk("rstMid_pos_y", pos_y, 100);
        chk("rstMid_settling", settling, 0);
        chk("rstMid_dir", dir, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pushExp(1, 0, 101, 100, 4'b0001);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (moved) begin
                n = i;
                break;
            end
        end
        // Tick lands TICK_DIV cycles after release, the move one edge later
        chk("firstMoveAfterRst", n, 5);
        drain("postResetMove");

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
